// File: rtl/branch_cmp_pred.sv
// Branch resolution for the ID stage: operand compare, 2-bit PHT predictor
// read by IF and trained by ID, misprediction flag and saturating statistics.
module branch_cmp_pred #(
  parameter int WIDTH    = 32,
  parameter int PHT_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [3:0]       cmp_op,
  input  logic             br_valid,
  input  logic             stall,
  input  logic [31:0]      pc_id,
  input  logic             pred_id,
  input  logic [31:0]      pc_if,
  output logic             taken,
  output logic             pred_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int ENTRIES = 1 << PHT_BITS;

  logic [1:0]          pht_q [ENTRIES];
  logic [1:0]          pht_d [ENTRIES];
  logic [CNT_W-1:0]    br_count_q, br_count_d;
  logic [CNT_W-1:0]    miss_count_q, miss_count_d;
  logic [PHT_BITS-1:0] idx_if, idx_id;
  logic                valid_op, upd, taken_c;
  logic [1:0]          cur_ctr, nxt_ctr;
  logic                unused_pc;

  assign idx_if    = pc_if[PHT_BITS+1:2];
  assign idx_id    = pc_id[PHT_BITS+1:2];
  assign unused_pc = ^{pc_if[31:PHT_BITS+2], pc_if[1:0], pc_id[31:PHT_BITS+2], pc_id[1:0]};

  always_comb begin
    taken_c = 1'b0;
    case (cmp_op)
      4'd1:    taken_c = (D1 == D2);
      4'd2:    taken_c = (D1 != D2);
      4'd3:    taken_c = D1[WIDTH-1] | (D1 == '0);
      4'd4:    taken_c = ~D1[WIDTH-1] & (D1 != '0);
      4'd5:    taken_c = D1[WIDTH-1];
      4'd6:    taken_c = ~D1[WIDTH-1];
      4'd7:    taken_c = ($signed(D1) < $signed(D2));
      4'd8:    taken_c = (D1 < D2);
      default: taken_c = 1'b0;
    endcase
  end

  // Reserved and "none" ops neither train the predictor nor count as branches
  assign valid_op   = (cmp_op != 4'd0) && (cmp_op <= 4'd8);
  assign upd        = br_valid & ~stall & valid_op;
  assign taken      = taken_c;
  assign mispredict = upd & (taken_c != pred_id);
  assign pred_taken = pht_q[idx_if][1];

  always_comb begin
    cur_ctr = pht_q[idx_id];
    nxt_ctr = cur_ctr;
    if (taken_c && cur_ctr != 2'b11) begin
      nxt_ctr = cur_ctr + 2'd1;
    end else if (!taken_c && cur_ctr != 2'b00) begin
      nxt_ctr = cur_ctr - 2'd1;
    end
    pht_d = pht_q;
    if (upd) begin
      pht_d[idx_id] = nxt_ctr;
    end
  end

  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (upd && br_count_q != '1) begin
      br_count_d = br_count_q + CNT_W'(1);
    end
    if (mispredict && miss_count_q != '1) begin
      miss_count_d = miss_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      pht_q        <= pht_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign br_count   = br_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_cmp_pred.sv
// Directed bench for branch_cmp_pred: op sweep table plus hand-written
// sequences for PHT training, stall, counter saturation and async reset.
module tb_branch_cmp_pred;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d1, d2;
  logic [3:0]  cmp_op;
  logic        br_valid, stall, pred_id;
  logic [31:0] pc_id, pc_if;
  logic        taken, pred_taken, mispredict;
  logic [31:0] br_count, miss_count;
  logic        taken4, pred_taken4, mispredict4;
  logic [3:0]  br_count4, miss_count4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] op;
    logic       exp_taken;
    logic       exp_miss;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  branch_cmp_pred #(.WIDTH(32), .PHT_BITS(6), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .D1(d1), .D2(d2), .cmp_op(cmp_op),
    .br_valid(br_valid), .stall(stall), .pc_id(pc_id), .pred_id(pred_id),
    .pc_if(pc_if), .taken(taken), .pred_taken(pred_taken),
    .mispredict(mispredict), .br_count(br_count), .miss_count(miss_count)
  );

  // Narrow-counter build to reach saturation in a handful of branches
  branch_cmp_pred #(.WIDTH(32), .PHT_BITS(6), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .D1(d1), .D2(d2), .cmp_op(cmp_op),
    .br_valid(br_valid), .stall(stall), .pc_id(pc_id), .pred_id(pred_id),
    .pc_if(pc_if), .taken(taken4), .pred_taken(pred_taken4),
    .mispredict(mispredict4), .br_count(br_count4), .miss_count(miss_count4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic bv,
                               input logic st, input logic [31:0] pcid,
                               input logic pred, input logic [31:0] pcif);
    cmp_op   = op;
    d1       = a;
    d2       = b;
    br_valid = bv;
    stall    = st;
    pc_id    = pcid;
    pred_id  = pred;
    pc_if    = pcif;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_pred_a [4];
    logic       exp_pred_b [4];
    logic       acc;
    logic [3:0] exp4;

    vecs[0]  = '{4'd0,  1'b0, 1'b0};
    vecs[1]  = '{4'd1,  1'b0, 1'b1};
    vecs[2]  = '{4'd2,  1'b1, 1'b0};
    vecs[3]  = '{4'd3,  1'b1, 1'b0};
    vecs[4]  = '{4'd4,  1'b0, 1'b1};
    vecs[5]  = '{4'd5,  1'b1, 1'b0};
    vecs[6]  = '{4'd6,  1'b0, 1'b1};
    vecs[7]  = '{4'd7,  1'b1, 1'b0};
    vecs[8]  = '{4'd8,  1'b0, 1'b1};
    vecs[9]  = '{4'd9,  1'b0, 1'b0};
    vecs[10] = '{4'd10, 1'b0, 1'b0};
    vecs[11] = '{4'd11, 1'b0, 1'b0};
    vecs[12] = '{4'd12, 1'b0, 1'b0};
    vecs[13] = '{4'd13, 1'b0, 1'b0};
    vecs[14] = '{4'd14, 1'b0, 1'b0};
    vecs[15] = '{4'd15, 1'b0, 1'b0};
    exp_pred_a = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_pred_b = '{1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_3004);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_br_count", br_count, 32'd0);
    checkOutput("reset_miss_count", miss_count, 32'd0);
    checkOutput("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    reset = 1'b0;

    // Op sweep, pred_id=1 so not-taken valid ops mispredict
    $display("[TB] op sweep");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0,
                    32'h0000_0028, 1'b1, 32'h0000_0028);
      checkOutput($sformatf("sweep_taken_op%0d", i), {31'd0, taken}, {31'd0, vecs[i].exp_taken});
      checkOutput($sformatf("sweep_miss_op%0d", i), {31'd0, mispredict}, {31'd0, vecs[i].exp_miss});
      tick();
    end
    checkOutput("sweep_br_count", br_count, 32'd8);
    checkOutput("sweep_miss_count", miss_count, 32'd4);
    checkOutput("sweep_br_count4", {28'd0, br_count4}, 32'd8);

    reset = 1'b1;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_3004);
    checkOutput("reset2_br_count", br_count, 32'd0);
    reset = 1'b0;

    // Four taken updates at index 1, IF reading the same entry
    $display("[TB] taken walk");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd1, 32'd5, 32'd5, 1'b1, 1'b0, 32'h0000_3004, 1'b0, 32'h0000_3004);
      checkOutput($sformatf("walk_up_pred%0d", i), {31'd0, pred_taken}, {31'd0, exp_pred_a[i]});
      checkOutput($sformatf("walk_up_miss%0d", i), {31'd0, mispredict}, 32'd1);
      tick();
    end
    checkOutput("walk_up_br_count", br_count, 32'd4);
    checkOutput("walk_up_miss_count", miss_count, 32'd4);
    checkOutput("walk_up_pred_final", {31'd0, pred_taken}, 32'd1);

    // Four not-taken updates: 11->10->01->00->00
    $display("[TB] not-taken walk");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd1, 32'd5, 32'd6, 1'b1, 1'b0, 32'h0000_3004, 1'b1, 32'h0000_3004);
      checkOutput($sformatf("walk_dn_pred%0d", i), {31'd0, pred_taken}, {31'd0, exp_pred_b[i]});
      tick();
    end
    checkOutput("walk_dn_pred_final", {31'd0, pred_taken}, 32'd0);
    checkOutput("walk_dn_br_count", br_count, 32'd8);
    checkOutput("walk_dn_miss_count", miss_count, 32'd8);

    // Stalled branch at index 2 counted once on release
    $display("[TB] stall");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'd1, 32'd7, 32'd7, 1'b1, 1'b1, 32'h0000_3008, 1'b0, 32'h0000_3008);
      checkOutput($sformatf("stall_miss%0d", i), {31'd0, mispredict}, 32'd0);
      tick();
      checkOutput($sformatf("stall_br_count%0d", i), br_count, 32'd8);
      checkOutput($sformatf("stall_pred%0d", i), {31'd0, pred_taken}, 32'd0);
    end
    applyStimulus(4'd1, 32'd7, 32'd7, 1'b1, 1'b0, 32'h0000_3008, 1'b0, 32'h0000_3008);
    checkOutput("release_miss", {31'd0, mispredict}, 32'd1);
    tick();
    checkOutput("release_br_count", br_count, 32'd9);
    checkOutput("release_miss_count", miss_count, 32'd9);
    checkOutput("release_pred", {31'd0, pred_taken}, 32'd1);
    applyStimulus(4'd1, 32'd7, 32'd8, 1'b1, 1'b0, 32'h0000_3008, 1'b0, 32'h0000_3008);
    tick();
    checkOutput("single_step_pred", {31'd0, pred_taken}, 32'd0);
    checkOutput("single_step_br_count", br_count, 32'd10);
    checkOutput("single_step_miss_count", miss_count, 32'd9);

    // Saturation of the 4-bit counters
    $display("[TB] saturation");
    reset = 1'b1;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_000C);
    checkOutput("reset3_br_count4", {28'd0, br_count4}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(4'd1, 32'd1, 32'd2, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_000C);
      tick();
      exp4 = (i >= 14) ? 4'hF : 4'(i + 1);
      checkOutput($sformatf("sat_br_count4_%0d", i), {28'd0, br_count4}, {28'd0, exp4});
      checkOutput($sformatf("sat_miss_count4_%0d", i), {28'd0, miss_count4}, {28'd0, exp4});
    end
    checkOutput("sat_br_count32", br_count, 32'd17);
    checkOutput("sat_miss_count32", miss_count, 32'd17);

    // Async reset mid-cycle after training index 1 to 11
    $display("[TB] async reset");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'd1, 32'd3, 32'd3, 1'b1, 1'b0, 32'h0000_3004, 1'b0, 32'h0000_3004);
      tick();
    end
    checkOutput("pre_reset_pred", {31'd0, pred_taken}, 32'd1);
    checkOutput("pre_reset_br_count", br_count, 32'd19);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_br_count", br_count, 32'd0);
    checkOutput("async_miss_count", miss_count, 32'd0);
    checkOutput("async_br_count4", {28'd0, br_count4}, 32'd0);
    checkOutput("async_pred", {31'd0, pred_taken}, 32'd0);
    acc = 1'b0;
    for (int j = 0; j < 64; j++) begin
      pc_if = 32'(j) << 2;
      #1;
      acc = acc | pred_taken;
    end
    checkOutput("async_all_pred", {31'd0, acc}, 32'd0);
    checkOutput("held_reset_br_count", br_count, 32'd0);
    checkOutput("held_reset_miss_count", miss_count, 32'd0);
    pc_if = 32'h0000_3004;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_pred_before", {31'd0, pred_taken}, 32'd0);
    tick();
    checkOutput("post_reset_pred_after", {31'd0, pred_taken}, 32'd1);
    checkOutput("post_reset_br_count", br_count, 32'd1);
    checkOutput("post_reset_miss_count", miss_count, 32'd1);

    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_cmp_pred.md
Name: branch_cmp_pred

Overview:
- Branch resolution unit for the ID stage of the pipelined MIPS core. Next generation of the single-cycle branch comparator.
- Width-parametrised compare with an extended condition set.
- Adds a pattern history table (PHT) of 2-bit saturating counters. The IF stage reads it for prediction; the ID stage updates it on resolve.
- Flags mispredictions and keeps saturating branch/miss statistics counters.

Parameters:
- WIDTH, 32, operand width in bits.
- PHT_BITS, 6, log2 of PHT entries (64 entries); index = pc[PHT_BITS+1:2].
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- D1  input  WIDTH  rs operand (already forwarded).
- D2  input  WIDTH  rt operand (already forwarded).
- cmp_op  input  4  0 none, 1 eq, 2 ne, 3 lez, 4 gtz, 5 ltz, 6 gez, 7 lt (signed D1<D2), 8 ltu (unsigned D1<D2); 9-15 reserved.
- br_valid  input  1  a conditional branch occupies ID this cycle.
- stall  input  1  ID stage held by hazard unit.
- pc_id  input  32  PC of the branch in ID.
- pred_id  input  1  prediction carried with the branch from IF.
- pc_if  input  32  PC being fetched.
- taken  output  1  combinational branch outcome.
- pred_taken  output  1  combinational prediction for pc_if.
- mispredict  output  1  combinational: br_valid & ~stall & (taken != pred_id).
- br_count  output  CNT_W  resolved-branch count.
- miss_count  output  CNT_W  misprediction count.

Behaviour:
- Compare: taken is fully combinational and has a defined value for every cmp_op (no latches).
  - Ops 3-6 compare D1 as signed against 0.
  - Op 7 is a signed compare; op 8 is unsigned.
  - cmp_op 0 and 9-15 give taken=0.
- PHT: 2^PHT_BITS entries, each 2 bits.
  - On reset, all entries go to 2'b01 (weakly not taken).
  - pred_taken = PHT[pc_if[PHT_BITS+1:2]][1], an asynchronous read.
- Update strobe: upd = br_valid & ~stall & (cmp_op in 1..8).
  - On the clk edge with upd, entry PHT[pc_id[PHT_BITS+1:2]] moves one step: increment if taken, decrement if not.
  - Counters saturate at 2'b11 and 2'b00; no wrap.
  - While stall=1, no update and no count. The branch is counted exactly once, on the cycle it leaves ID.
- Same-index read/write: if pc_if and pc_id map to the same entry in the update cycle, pred_taken shows the pre-update value. The new value is visible from the next cycle.
- Stats:
  - br_count increments on every upd edge.
  - miss_count increments on upd & mispredict.
  - Both saturate at all-ones and never wrap.
- mispredict is forced to 0 when cmp_op is 0 or reserved.
- Reset:
  - Asserting reset mid-operation immediately clears br_count and miss_count to 0 and the PHT to 2'b01, regardless of the clock.
  - Outputs are combinational from cleared state: pred_taken=0; taken still follows D1/D2/cmp_op.
  - No update occurs on any edge while reset is high.
- Latency: compare and mispredict 0 cycles; PHT update and stats 1 cycle (visible after the edge).

Test Plan:
- Reset, then sweep every op with D1=32'hFFFF_FFFF, D2=32'h0000_0001.
  - Expected: eq 0, ne 1, lez 1, gtz 0, ltz 1, gez 0, lt 1, ltu 0; ops 0 and 9-15 give 0.
- pc_id=pc_if=32'h0000_3004 (index 1), four taken updates with pred_id=0.
  - Entry walks 01→10→11→11.
  - pred_taken is 0 during the first update cycle (old-value read), then 1.
  - br_count=4, miss_count=4.
- From entry 11 at index 1, three not-taken updates.
  - Entry walks 11→10→01→00.
  - A further not-taken update keeps it at 00.
  - pred_taken drops to 0 after the second update.
- br_valid=1, taken branch, stall held high 3 cycles then released 1 cycle.
  - Only one PHT step.
  - br_count +1 only on the release edge.
  - mispredict is 0 while stalled.
- Force br_count to all-ones (CNT_W=4 build: 15 updates, then a 16th).
  - br_count stays 4'hF.
  - miss_count saturates the same way.
- Assert reset asynchronously between edges after several updates.
  - Counters read 0 and all PHT entries read 01 before the next clk edge.
  - No update occurs on an edge while reset is high.
